booth_seq_mult: RTL and testbench

- Parametrised, iterative radix-2 Booth multiplier.
- Successor to the team's 4-bit combinational Booth block: adds generic operand width, run-time signed/unsigned mode and an optional clamp-negative-to-zero mode.
- Valid/ready handshake on both input and output.
- Spends one clock per Booth step, trading latency for area on the shared datapath of the tile.

---
 rtl/booth_seq_mult.sv | 120 ++++++++++++
 tb/tb_booth_seq_mult.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock over WIDTH+1 steps,
// with run-time signed/unsigned operands, optional negative clamp and valid/ready on both sides.
`timescale 1ns/1ps

module booth_seq_mult #(
  parameter int WIDTH     = 8,
  parameter int CLAMP_NEG = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_x,
  input  logic [WIDTH-1:0]   op_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               neg,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH+1:0]     r_acc;
  logic [WIDTH:0]       r_q;
  logic                 r_e;
  logic [WIDTH:0]       r_y;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_neg;

  logic [WIDTH+1:0]     w_y_ext;
  logic [WIDTH+1:0]     w_acc_sum;
  logic [WIDTH+1:0]     w_acc_sh;
  logic [WIDTH:0]       w_q_sh;
  logic                 w_e_sh;
  logic                 w_last;
  logic                 w_neg;
  logic [2*WIDTH-1:0]   w_prod;

  // Operands carry one extra bit so unsigned max and signed min both stay exact.
  assign w_y_ext = {r_y[WIDTH], r_y};
  assign w_last  = (r_cnt == CW'(WIDTH));

  always_comb begin
    w_acc_sum = r_acc;
    case ({r_q[0], r_e})
      2'b10:   w_acc_sum = r_acc - w_y_ext;
      2'b01:   w_acc_sum = r_acc + w_y_ext;
      default: w_acc_sum = r_acc;
    endcase
  end

  assign {w_acc_sh, w_q_sh, w_e_sh} = {w_acc_sum[WIDTH+1], w_acc_sum, r_q};
  assign w_neg  = w_acc_sh[WIDTH+1];
  assign w_prod = {w_acc_sh[WIDTH-2:0], w_q_sh};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_q       <= '0;
      r_e       <= 1'b0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_neg     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc <= '0;
            r_e   <= 1'b0;
            r_cnt <= '0;
            r_q   <= {is_signed & op_x[WIDTH-1], op_x};
            r_y   <= {is_signed & op_y[WIDTH-1], op_y};
          end
        end
        S_RUN: begin
          r_acc <= w_acc_sh;
          r_q   <= w_q_sh;
          r_e   <= w_e_sh;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_neg     <= w_neg;
            r_product <= ((CLAMP_NEG != 0) && w_neg) ? '0 : w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;
  assign neg       = r_neg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult: 8-bit instances with and without clamp, plus a 4-bit instance
// swept over every operand pair; results scored against a plain-arithmetic multiply model.
`timescale 1ns/1ps

module tb_booth_seq_mult;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid8, is_signed8, out_ready8;
  logic [7:0]  x8, y8;
  logic        in_ready8, out_valid8, neg8, busy8;
  logic        in_ready8c, out_valid8c, neg8c, busy8c;
  logic [15:0] prod8, prod8c;

  logic        in_valid4, is_signed4, out_ready4;
  logic [3:0]  x4, y4;
  logic        in_ready4, out_valid4, neg4, busy4;
  logic [7:0]  prod4;

  booth_seq_mult #(.WIDTH(W8), .CLAMP_NEG(0)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .is_signed(is_signed8), .op_x(x8), .op_y(y8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(prod8), .neg(neg8), .busy(busy8)
  );

  booth_seq_mult #(.WIDTH(W8), .CLAMP_NEG(1)) u8c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8c),
    .is_signed(is_signed8), .op_x(x8), .op_y(y8), .out_valid(out_valid8c),
    .out_ready(out_ready8), .product(prod8c), .neg(neg8c), .busy(busy8c)
  );

  booth_seq_mult #(.WIDTH(W4), .CLAMP_NEG(0)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .is_signed(is_signed4), .op_x(x4), .op_y(y4), .out_valid(out_valid4),
    .out_ready(out_ready4), .product(prod4), .neg(neg4), .busy(busy4)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: extend each operand to its true integer value and multiply.
  function automatic longint ref_mul(input int w, input bit sgn, input int x, input int y);
    longint xs, ys;
    xs = x;
    ys = y;
    if (sgn && x >= (1 << (w - 1))) xs = longint'(x) - (longint'(1) << w);
    if (sgn && y >= (1 << (w - 1))) ys = longint'(y) - (longint'(1) << w);
    return xs * ys;
  endfunction

  function automatic logic [15:0] ref_prod(input int w, input longint p, input bit clamp);
    longint mask;
    mask = (longint'(1) << (2 * w)) - 1;
    if (clamp && p < 0) return 16'h0000;
    return 16'(p & mask);
  endfunction

  typedef struct {
    logic [15:0] prod;
    logic [15:0] prod_c;
    logic        neg;
    int          acc_cyc;
    bit          seen;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  // Per-cycle scoring of the 8-bit pair; a pending entry means the block must be busy.
  always @(negedge clk) begin
    exp_t e;
    longint p;
    if (!rst_n) begin
      q8.delete();
    end else begin
      chk("in_ready8", in_ready8, q8.size() == 0);
      chk("busy8", busy8, q8.size() != 0);
      chk("in_ready8c", in_ready8c, q8.size() == 0);
      if (out_valid8) begin
        if (q8.size() == 0) begin
          chk("spurious_valid8", out_valid8, 1'b0);
        end else begin
          if (!q8[0].seen) begin
            // accepting edge counted as the first
            chk("latency8", cyc - q8[0].acc_cyc + 1, W8 + 2);
            q8[0].seen = 1'b1;
          end
          chk("prod8", prod8, q8[0].prod);
          chk("neg8", neg8, q8[0].neg);
          chk("valid8c", out_valid8c, 1'b1);
          chk("prod8c", prod8c, q8[0].prod_c);
          chk("neg8c", neg8c, q8[0].neg);
          if (out_ready8) void'(q8.pop_front());
        end
      end else if (q8.size() != 0 && q8[0].seen) begin
        chk("valid8_dropped", out_valid8, 1'b1);
      end else if (q8.size() != 0 && (cyc - q8[0].acc_cyc + 1) > W8 + 2) begin
        chk("valid8_late", out_valid8, 1'b1);
      end
      if (in_valid8 && in_ready8) begin
        p = ref_mul(W8, is_signed8, int'(x8), int'(y8));
        e.prod    = ref_prod(W8, p, 1'b0);
        e.prod_c  = ref_prod(W8, p, 1'b1);
        e.neg     = (p < 0);
        e.acc_cyc = cyc + 1;
        e.seen    = 1'b0;
        q8.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    longint p;
    if (!rst_n) begin
      q4.delete();
    end else begin
      chk("in_ready4", in_ready4, q4.size() == 0);
      if (out_valid4) begin
        if (q4.size() == 0) begin
          chk("spurious_valid4", out_valid4, 1'b0);
        end else begin
          if (!q4[0].seen) begin
            chk("latency4", cyc - q4[0].acc_cyc + 1, W4 + 2);
            q4[0].seen = 1'b1;
          end
          chk("prod4", prod4, q4[0].prod);
          chk("neg4", neg4, q4[0].neg);
          if (out_ready4) void'(q4.pop_front());
        end
      end else if (q4.size() != 0 && (cyc - q4[0].acc_cyc + 1) > W4 + 2) begin
        chk("valid4_late", out_valid4, 1'b1);
      end
      if (in_valid4 && in_ready4) begin
        p = ref_mul(W4, is_signed4, int'(x4), int'(y4));
        e.prod    = ref_prod(W4, p, 1'b0);
        e.prod_c  = e.prod;
        e.neg     = (p < 0);
        e.acc_cyc = cyc + 1;
        e.seen    = 1'b0;
        q4.push_back(e);
      end
    end
  end

  task automatic issue8(input bit sgn, input logic [7:0] x, input logic [7:0] y);
    bit acc;
    int guard;
    is_signed8 = sgn;
    x8 = x;
    y8 = y;
    in_valid8 = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready8;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid8  = 1'b0;
    // scramble operands after acceptance; the block must ignore them
    x8         = 8'($urandom);
    y8         = 8'($urandom);
    is_signed8 = 1'($urandom);
    if (!acc) chk("accept8_timeout", acc, 1'b1);
  endtask

  task automatic wait_valid8();
    int guard;
    guard = 0;
    while (!out_valid8 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("valid8_wait", out_valid8, 1'b1);
  endtask

  task automatic run8(input bit sgn, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp_p, input logic [15:0] exp_pc,
                      input bit exp_n, input bit early_ready);
    out_ready8 = early_ready;
    issue8(sgn, x, y);
    wait_valid8();
    chk("lit_prod8", prod8, exp_p);
    chk("lit_prod8c", prod8c, exp_pc);
    chk("lit_neg8", neg8, exp_n);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int guard;
    bit acc;

    rst_n = 1'b0;
    in_valid8 = 1'b0; is_signed8 = 1'b0; out_ready8 = 1'b0; x8 = '0; y8 = '0;
    in_valid4 = 1'b0; is_signed4 = 1'b0; out_ready4 = 1'b0; x4 = '0; y4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid8", out_valid8, 1'b0);
    chk("rst_prod8", prod8, 16'h0000);
    chk("rst_neg8", neg8, 1'b0);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_ready8", in_ready8, 1'b1);
    chk("rst_prod4", prod4, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors: sgn, x, y, product, clamped product, neg, out_ready early
    run8(1'b1, 8'h80, 8'h80, 16'h4000, 16'h4000, 1'b0, 1'b0);
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 16'hFE01, 1'b0, 1'b0);
    run8(1'b1, 8'hFF, 8'hFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run8(1'b1, 8'hFD, 8'h05, 16'hFFF1, 16'h0000, 1'b1, 1'b0);
    run8(1'b0, 8'h00, 8'h5A, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run8(1'b1, 8'h7F, 8'h80, 16'hC080, 16'h0000, 1'b1, 1'b1);
    run8(1'b0, 8'h80, 8'h80, 16'h4000, 16'h4000, 1'b0, 1'b1);
    run8(1'b1, 8'h02, 8'h81, 16'hFF02, 16'h0000, 1'b1, 1'b0);
    run8(1'b0, 8'hFD, 8'h05, 16'h04F1, 16'h04F1, 1'b0, 1'b0);

    // backpressure: 0x12*0x34 = 0x03A8 held through a 12-cycle stall
    out_ready8 = 1'b0;
    issue8(1'b1, 8'h12, 8'h34);
    wait_valid8();
    for (int i = 0; i < 12; i++) begin
      if (i == 4 || i == 5) begin
        in_valid8 = 1'b1; x8 = 8'h55; y8 = 8'h66; is_signed8 = 1'b0;
      end else begin
        in_valid8 = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("stall_prod8", prod8, 16'h03A8);
      chk("stall_valid8", out_valid8, 1'b1);
      chk("stall_ready8", in_ready8, 1'b0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    run8(1'b0, 8'h03, 8'h04, 16'h000C, 16'h000C, 1'b0, 1'b0);

    // reset during the third Booth step aborts the operation
    out_ready8 = 1'b0;
    issue8(1'b0, 8'h0B, 8'h0D);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_ready8", in_ready8, 1'b1);
    chk("abort_valid8", out_valid8, 1'b0);
    chk("abort_prod8", prod8, 16'h0000);
    chk("abort_neg8", neg8, 1'b0);
    chk("abort_busy8", busy8, 1'b0);
    run8(1'b0, 8'h07, 8'h06, 16'h002A, 16'h002A, 1'b0, 1'b0);

    // 4-bit sweep, back to back; each accept must follow the previous by 7 edges
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    prev = -1;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          is_signed4 = 1'(s);
          x4 = 4'(x);
          y4 = 4'(y);
          acc = 1'b0;
          guard = 0;
          while (!acc && guard < 20) begin
            @(negedge clk);
            acc = in_ready4;
            @(posedge clk);
            #1;
            guard++;
          end
          if (!acc) chk("accept4_timeout", acc, 1'b1);
          else if (prev >= 0) chk("interval4", cyc - prev, W4 + 3);
          prev = cyc;
        end
      end
    end
    in_valid4 = 1'b0;
    guard = 0;
    while (q4.size() != 0 && guard < 30) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain4", q4.size(), 0);
    chk("drain8", q8.size(), 0);
    chk("lit_4bit_last", prod4, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
